// File: rtl/fifo_feed_ctrl.sv
// Sequences the DIM row delay fifos feeding the systolic array: FILL loads one column word per
// read, DRAIN shifts the fifos out with a per-row skew, then a one-cycle done pulse.
module fifo_feed_ctrl #(
    parameter int unsigned DIM  = 8,
    parameter int unsigned BITS = 8,
    localparam int unsigned AW  = (DIM > 1) ? $clog2(DIM) : 1,
    localparam int unsigned KW  = $clog2(3 * DIM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_req,
    output logic [AW-1:0]       mem_rd_addr,
    input  logic                mem_rd_valid,
    input  logic [DIM*BITS-1:0] mem_rd_data,
    output logic [DIM-1:0]      fifo_en,
    output logic [DIM*BITS-1:0] fifo_d,
    output logic                array_en
);

    typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

    localparam logic [AW-1:0] CLast = AW'(DIM - 1);
    localparam logic [KW-1:0] KLast = KW'(3 * DIM - 3);

    state_e        state_q, state_d;
    logic [AW-1:0] c_q, c_d;
    logic [KW-1:0] k_q, k_d;
    logic          pend_q, pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            c_q     <= '0;
            k_q     <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        k_d         = k_q;
        pend_d      = pend_q;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_req  = 1'b0;
        mem_rd_addr = c_q;
        fifo_en     = '0;
        fifo_d      = '0;
        array_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFill;
                    c_d     = '0;
                    pend_d  = 1'b0;
                end
            end
            StFill: begin
                busy = 1'b1;
                // Valid only counts while a read is outstanding; one read in flight at most.
                if (!pend_q) begin
                    mem_rd_req = 1'b1;
                    pend_d     = 1'b1;
                end else if (mem_rd_valid) begin
                    fifo_en = '1;
                    fifo_d  = mem_rd_data;
                    pend_d  = 1'b0;
                    if (c_q == CLast) begin
                        state_d = StDrain;
                        c_d     = '0;
                        k_d     = '0;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (!stall) begin
                    array_en = 1'b1;
                    // Row i shifts during k in [i, i+DIM): the skewed diagonal wavefront.
                    for (int i = 0; i < int'(DIM); i++) begin
                        fifo_en[i] = (int'(k_q) >= i) && (int'(k_q) < i + int'(DIM));
                    end
                    if (k_q == KLast) begin
                        state_d = StDone;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_fifo_feed_ctrl.sv
// Bench for fifo_feed_ctrl (DIM=4, BITS=8): per-cycle vector table built from job descriptions
// (memory latency, stall pattern, start behaviour), then applied and compared cycle by cycle.
module tb_fifo_feed_ctrl;

    localparam int DIM  = 4;
    localparam int BITS = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                stall = 1'b0;
    logic                busy, done, mem_rd_req, array_en;
    logic [1:0]          mem_rd_addr;
    logic                mem_rd_valid = 1'b0;
    logic [DIM*BITS-1:0] mem_rd_data = '0;
    logic [DIM-1:0]      fifo_en;
    logic [DIM*BITS-1:0] fifo_d;

    always #5 clk = ~clk;

    fifo_feed_ctrl #(.DIM(DIM), .BITS(BITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .fifo_en      (fifo_en),
        .fifo_d       (fifo_d),
        .array_en     (array_en)
    );

    typedef struct {
        bit          rst;
        bit          start;
        bit          stall;
        bit          vld;
        logic [31:0] data;
        bit          busy;
        bit          done;
        bit          req;
        logic [1:0]  addr;
        logic [3:0]  fen;
        logic [31:0] fd;
        bit          aen;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] dcols [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    int          total = 0;
    int          bad = 0;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Rows whose skew window [i, i+DIM) contains drain step k.
    function automatic logic [3:0] mask(int k);
        logic [3:0] m;
        for (int i = 0; i < DIM; i++) m[i] = (k >= i) && (k < i + DIM);
        return m;
    endfunction

    function automatic void add(bit rst, bit st, bit sl, bit vl, logic [31:0] d, bit b, bit dn,
                                bit rq, logic [1:0] ad, logic [3:0] fe, logic [31:0] fd,
                                bit ae);
        vec_t v;
        v = '{rst, st, sl, vl, d, b, dn, rq, ad, fe, fd, ae};
        vq.push_back(v);
    endfunction

    function automatic void add_idle(bit st);
        add(0, st, rb(), rb(), $urandom, 0, 0, 0, 2'd0, 4'h0, 32'h0, 0);
    endfunction

    // lat=0 -> random 1..4 per column; stall_mode 0 none, 1 random, 2 three cycles at k=2;
    // abort_k >= 0 asserts reset on reaching that drain step.
    function automatic void push_job(int lat_fix, int stall_mode, bit hold, int abort_k,
                                     bit fixed_cols);
        logic [31:0] col;
        int          lat;
        int          k;
        int          stall_left;
        bit          s;
        add(0, 1, rb(), rb(), $urandom, 0, 0, 0, 2'd0, 4'h0, 32'h0, 0);
        for (int c = 0; c < DIM; c++) begin
            col = fixed_cols ? dcols[c] : $urandom;
            lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
            add(0, hold | rb(), rb(), rb(), $urandom, 1, 0, 1, 2'(c), 4'h0, 32'h0, 0);
            for (int w = 1; w < lat; w++)
                add(0, hold | rb(), rb(), 0, $urandom, 1, 0, 0, 2'(c), 4'h0, 32'h0, 0);
            add(0, hold | rb(), rb(), 1, col, 1, 0, 0, 2'(c), 4'hF, col, 0);
        end
        k = 0;
        stall_left = (stall_mode == 2) ? 3 : 0;
        while (k < 3 * DIM - 2) begin
            if (abort_k == k) begin
                add(1, 0, 0, 0, 32'h0, 0, 0, 0, 2'd0, 4'h0, 32'h0, 0);
                return;
            end
            if (stall_mode == 1) s = ($urandom_range(0, 3) == 0);
            else s = (stall_mode == 2) && (k == 2) && (stall_left > 0);
            if (s) begin
                stall_left--;
                add(0, hold | rb(), 1, rb(), $urandom, 1, 0, 0, 2'd0, 4'h0, 32'h0, 0);
            end else begin
                add(0, hold | rb(), 0, rb(), $urandom, 1, 0, 0, 2'd0, mask(k), 32'h0, 1);
                k++;
            end
        end
        add(0, hold | rb(), rb(), rb(), $urandom, 0, 1, 0, 2'd0, 4'h0, 32'h0, 0);
        add_idle(0);
    endfunction

    task automatic check(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        add(1, 0, 0, 0, 32'h0, 0, 0, 0, 2'd0, 4'h0, 32'h0, 0);
        add(1, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 2'd0, 4'h0, 32'h0, 0);
        // Spurious valids while idle must not reach the fifos.
        add(0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 2'd0, 4'h0, 32'h0, 0);
        add(0, 0, 1, 1, 32'h12345678, 0, 0, 0, 2'd0, 4'h0, 32'h0, 0);
        push_job(1, 0, 0, -1, 1);
        add(0, 0, 0, 1, 32'hA5A5A5A5, 0, 0, 0, 2'd0, 4'h0, 32'h0, 0);
        push_job(3, 0, 0, -1, 1);
        push_job(1, 2, 0, -1, 1);
        push_job(1, 0, 1, -1, 1);
        push_job(2, 0, 0, 5, 0);
        add_idle(0);
        add_idle(0);
        push_job(0, 0, 0, -1, 0);
        for (int j = 0; j < 20; j++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) add_idle(0);
            push_job(0, 1, 0, -1, 0);
        end

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n        = !vq[i].rst;
            start        = vq[i].start;
            stall        = vq[i].stall;
            mem_rd_valid = vq[i].vld;
            mem_rd_data  = vq[i].data;
            @(negedge clk);
            check("busy", i, 32'(busy), 32'(vq[i].busy));
            check("done", i, 32'(done), 32'(vq[i].done));
            check("mem_rd_req", i, 32'(mem_rd_req), 32'(vq[i].req));
            check("fifo_en", i, 32'(fifo_en), 32'(vq[i].fen));
            check("fifo_d", i, fifo_d, vq[i].fd);
            check("array_en", i, 32'(array_en), 32'(vq[i].aen));
            if (vq[i].req || vq[i].rst)
                check("mem_rd_addr", i, 32'(mem_rd_addr), 32'(vq[i].addr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
